usb_tx_arbiter: RTL and testbench

// - Upstream feeder of the FT601 write path: merges N peripheral TX FIFOs into the single

---
 rtl/usb_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_usb_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin burst arbiter that merges the peripheral TX FIFOs
// into the single lycan-out stream. Each output word carries its 3-bit source
// address. A 2-entry skid buffer absorbs the 1-cycle FIFO read latency.
module usb_tx_arbiter #(
    parameter int unsigned NUM_PERIPH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     periph_ready,
    input  logic [NUM_PERIPH-1:0]    periph_empty,
    output logic [NUM_PERIPH-1:0]    periph_rd_en,
    input  logic [NUM_PERIPH*29-1:0] periph_data,
    input  logic                     out_full,
    output logic                     out_wr_en,
    output logic [31:0]              out_data,
    output logic [2:0]               grant_out
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      grant, grant_nxt;
    logic [2:0]      rr_ptr, rr_nxt;
    logic [CW-1:0]   burst_cnt, cnt_nxt;

    logic            inflight;
    logic [2:0]      inflight_addr;
    logic [31:0]     skid0, skid1;
    logic [1:0]      skid_cnt;

    // Requests/empties widened to the full 3-bit address space; absent peripherals look empty.
    logic [7:0]      req8, empty8, rd8;
    logic            found;
    logic [2:0]      hit;
    logic            drain, space, issue, push;
    logic [2:0]      occ;
    logic [28:0]     payload;
    logic [31:0]     new_word;

    // Widen per-peripheral flags so addresses >= NUM_PERIPH are never requesters
    always_comb begin
        req8   = '0;
        empty8 = '1;
        req8[NUM_PERIPH-1:0]   = ~periph_empty;
        empty8[NUM_PERIPH-1:0] = periph_empty;
    end

    // Round-robin search starting one past the last granted peripheral
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        hit   = '0;
        for (int unsigned k = 1; k <= NUM_PERIPH; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_PERIPH) idx = idx - NUM_PERIPH;
            if (!found && req8[3'(idx)]) begin
                found = 1'b1;
                hit   = 3'(idx);
            end
        end
    end

    // Skid occupancy/space and the read-issue condition
    always_comb begin
        drain = (skid_cnt != 2'd0) && !out_full;
        occ   = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, drain};
        space = (occ < 3'd2);
        issue = (state == BURST) && periph_ready && !empty8[grant] && space;
        push  = inflight;
    end

    // Select the payload of the peripheral whose read is in flight
    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
            if (inflight_addr == 3'(i)) payload = periph_data[29*i +: 29];
        end
        new_word = {inflight_addr, payload};
    end

    // Next-state, grant bookkeeping and read strobes
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        cnt_nxt   = burst_cnt;
        rd8       = '0;
        case (state)
            IDLE: begin
                if (periph_ready && found) begin
                    grant_nxt = hit;
                    rr_nxt    = hit;
                    cnt_nxt   = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    rd8[grant] = 1'b1;
                    cnt_nxt    = burst_cnt + 1'b1;
                end
                if (!issue || (cnt_nxt == CW'(MAX_BURST)) || !periph_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= 3'(NUM_PERIPH - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Track the read in flight, tagged with the grant that issued it
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_addr <= grant;
        end
    end

    // Two-entry skid FIFO; skid0 is always the head so out_data comes straight from a register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= '0;
        end else begin
            case ({push, drain})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= new_word;
                    else                  skid1 <= new_word;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= new_word;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= new_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign periph_rd_en = rd8[NUM_PERIPH-1:0];
    assign out_wr_en    = drain;
    assign out_data     = skid0;
    assign grant_out    = grant;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed tests with a scoreboard of expected output words;
// a negedge monitor pops and compares on every out_wr_en.
module tb_usb_tx_arbiter;

    localparam int unsigned NP = 8;

    logic            clk = 1'b0;
    logic            rst_l = 1'b0;
    logic            periph_ready = 1'b0;
    logic [NP-1:0]   periph_empty;
    logic [NP-1:0]   periph_rd_en;
    logic [NP*29-1:0] periph_data;
    logic            out_full = 1'b0;
    logic            out_wr_en;
    logic [31:0]     out_data;
    logic [2:0]      grant_out;

    usb_tx_arbiter #(.NUM_PERIPH(NP), .MAX_BURST(16)) dut (
        .clk(clk), .rst_l(rst_l), .periph_ready(periph_ready),
        .periph_empty(periph_empty), .periph_rd_en(periph_rd_en),
        .periph_data(periph_data), .out_full(out_full),
        .out_wr_en(out_wr_en), .out_data(out_data), .grant_out(grant_out)
    );

    always #5 clk = ~clk;

    // Peripheral FIFO models: mem/tail written by stimulus, head/lane by the model
    logic [28:0] mem [NP][256];
    int          head [NP];
    int          tail [NP];
    logic [28:0] lane [NP];

    initial begin
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            tail[i] = 0;
            lane[i] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            periph_empty[i]         = (head[i] == tail[i]);
            periph_data[29*i +: 29] = lane[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (periph_rd_en[i]) begin
                lane[i] <= mem[i][head[i] % 256];
                head[i] <= head[i] + 1;
            end
        end
    end

    // Scoreboard and counters
    logic [31:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int rd_total = 0;
    int wr_total = 0;
    int serial = 100;

    // Read-burst log: peripheral, length and idle gap before each burst
    int run_who [$];
    int run_len [$];
    int run_gap [$];
    int cur_len = 0;
    int cur_who = 0;
    int cur_gap = 0;
    int gap_cnt = 0;

    // Monitor: compare each written word against the scoreboard, log read bursts
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_l) begin
            total++;
            if (!$onehot0(periph_rd_en)) begin
                bad++;
                $display("FAIL rd_onehot0: got %b required onehot0", periph_rd_en);
            end
            for (int i = 0; i < NP; i++) begin
                if (periph_rd_en[i] && periph_empty[i]) begin
                    total++;
                    bad++;
                    $display("FAIL rd_empty: periph %0d read while empty", i);
                end
            end
            rd_total += $countones(periph_rd_en);
            if (out_wr_en) begin
                wr_total++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected: got %08h required no write", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL out_data: got %08h required %08h", out_data, e);
                    end
                end
            end
        end
        if (periph_rd_en != '0) begin
            if (cur_len == 0) begin
                cur_gap = gap_cnt;
                for (int i = 0; i < NP; i++) if (periph_rd_en[i]) cur_who = i;
            end
            cur_len++;
            gap_cnt = 0;
        end else begin
            if (cur_len > 0) begin
                run_who.push_back(cur_who);
                run_len.push_back(cur_len);
                run_gap.push_back(cur_gap);
            end
            cur_len = 0;
            gap_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Append n words to a peripheral FIFO; returns the first payload serial
    task automatic load(input int p, input int n, output int first);
        first = serial;
        for (int k = 0; k < n; k++) mem[p][(tail[p] + k) % 256] = 29'(serial + k);
        serial += n;
        tail[p] = tail[p] + n;
    endtask

    task automatic expect_words(input int p, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({3'(p), 29'(first + k)});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_l = 1'b0;
        out_full = 1'b0;
        periph_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_run(input string name, input int idx, input int who, input int len);
        if (idx < run_who.size()) begin
            chk({name, "_who"}, 32'(run_who[idx]), 32'(who));
            chk({name, "_len"}, 32'(run_len[idx]), 32'(len));
        end else begin
            total++;
            bad++;
            $display("FAIL %s_missing: got %0d bursts required more than %0d", name, run_who.size(), idx);
        end
    endtask

    initial begin
        int f0, f3, f5, f1, f4, f6, f7, s, base, guard;

        // Reset state, all FIFOs empty
        do_reset();
        #1;
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_grant", 32'(grant_out), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_rd_en", 32'(periph_rd_en), 32'd0);
            chk("idle_wr_en", 32'(out_wr_en), 32'd0);
        end

        // Sole requester periph 2 with 40 words: bursts 16,16,8 with one idle gap
        @(posedge clk);
        #1 s = run_who.size();
        load(2, 40, f0);
        expect_words(2, f0, 40);
        wait_drain("t2_drain");
        chk("t2_bursts", 32'(run_who.size() - s), 32'd3);
        chk_run("t2_b0", s, 2, 16);
        chk_run("t2_b1", s + 1, 2, 16);
        chk_run("t2_b2", s + 2, 2, 8);
        if (s + 2 < run_gap.size()) begin
            chk("t2_gap1", 32'(run_gap[s + 1]), 32'd1);
            chk("t2_gap2", 32'(run_gap[s + 2]), 32'd1);
        end

        // Periphs 0,3,5 with 32 words each: grant order 0,3,5,0,3,5 in bursts of 16
        do_reset();
        #1 s = run_who.size();
        load(0, 32, f0);
        load(3, 32, f3);
        load(5, 32, f5);
        expect_words(0, f0, 16);
        expect_words(3, f3, 16);
        expect_words(5, f5, 16);
        expect_words(0, f0 + 16, 16);
        expect_words(3, f3 + 16, 16);
        expect_words(5, f5 + 16, 16);
        wait_drain("t3_drain");
        chk("t3_bursts", 32'(run_who.size() - s), 32'd6);
        chk_run("t3_b0", s, 0, 16);
        chk_run("t3_b1", s + 1, 3, 16);
        chk_run("t3_b2", s + 2, 5, 16);
        chk_run("t3_b3", s + 3, 0, 16);
        chk_run("t3_b4", s + 4, 3, 16);
        chk_run("t3_b5", s + 5, 5, 16);

        // out_full held for 10 cycles mid-burst
        do_reset();
        #1 base = wr_total;
        load(2, 30, f0);
        expect_words(2, f0, 30);
        guard = 0;
        while (wr_total < base + 8 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("t4_reach_mid", 32'(guard < 200), 32'd1);
        #1 out_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_full_wr_en", 32'(out_wr_en), 32'd0);
        end
        chk("t4_outstanding_le2", 32'((rd_total - wr_total) <= 2), 32'd1);
        @(posedge clk);
        #1 out_full = 1'b0;
        @(negedge clk);
        chk("t4_resume", 32'(out_wr_en), 32'd1);
        wait_drain("t4_drain");

        // Periph 1 runs dry after 5 words while periph 4 waits
        do_reset();
        #1 s = run_who.size();
        load(1, 5, f1);
        load(4, 6, f4);
        expect_words(1, f1, 5);
        expect_words(4, f4, 6);
        wait_drain("t5_drain");
        chk_run("t5_b0", s, 1, 5);
        chk_run("t5_b1", s + 1, 4, 6);
        chk("t5_grant", 32'(grant_out), 32'd4);

        // Reset with two words buffered; round-robin pointer must restart
        do_reset();
        #1 out_full = 1'b1;
        base = rd_total;
        load(6, 4, f6);
        repeat (10) @(posedge clk);
        chk("t6_reads_held", 32'(rd_total - base), 32'd2);
        #1 rst_l = 1'b0;
        out_full = 1'b0;
        #1;
        chk("t6_rst_rd_en", 32'(periph_rd_en), 32'd0);
        chk("t6_rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("t6_rst_data", out_data, 32'd0);
        chk("t6_rst_grant", 32'(grant_out), 32'd0);
        s = run_who.size();
        load(0, 3, f0);
        load(7, 2, f7);
        expect_words(0, f0, 3);
        expect_words(6, f6 + 2, 2);
        expect_words(7, f7, 2);
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        wait_drain("t6_drain");
        chk_run("t6_b0", s, 0, 3);
        chk_run("t6_b1", s + 1, 6, 2);
        chk_run("t6_b2", s + 2, 7, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
